cache_ctrl: RTL

- Direct-mapped, write-back, write-allocate controller that sequences the cache data memory (1-cycle registered-read SRAM indexed by cache_req_t.index with a we bit).
- Owns the valid/dirty/tag state, arbitrates between CPU accesses and line refill/eviction, and talks to a backing memory through a valid/ready request channel and a return-valid read channel.
- Line size is one cache_data_t word, so each index holds exactly one line.

---
 rtl/cache_ctrl_pkg.sv | 39 +++
 rtl/cache_tag_array.sv | 48 ++++
 rtl/cache_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and sizes for the direct-mapped write-back cache controller.
package cache_ctrl_pkg;

    localparam int unsigned INDEX_W = 10;
    localparam int unsigned TAG_W   = 20;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = TAG_W + INDEX_W;
    localparam int unsigned DEPTH   = 1 << INDEX_W;

    typedef logic [DATA_W-1:0] cache_data_t;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               we;
    } cache_req_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL_REQ,
        REFILL_WAIT,
        FILL,
        RESP
    } cache_ctrl_state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    // Build a word address from its tag and index fields.
    function automatic logic [ADDR_W-1:0] make_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index};
    endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Tag/valid/dirty store: registered read, synchronous write, valid/dirty cleared on reset.
module cache_tag_array
    import cache_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic [INDEX_W-1:0] rd_index,
    output tag_entry_t         rd_entry,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  tag_entry_t         wr_entry
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] dirty_q;
    logic [TAG_W-1:0] tag_mem [DEPTH];

    // Status bits; these are the only state that must be cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= wr_entry.valid;
            dirty_q[wr_index] <= wr_entry.dirty;
        end
    end

    // Tag storage, no reset needed since valid gates every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index] <= wr_entry.tag;
        end
    end

    // Registered read port, entry available the cycle after rd_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_entry <= '0;
        end else if (rd_en) begin
            rd_entry.valid <= valid_q[rd_index];
            rd_entry.dirty <= dirty_q[rd_index];
            rd_entry.tag   <= tag_mem[rd_index];
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller, one word per line.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  cache_data_t       cpu_wdata,
    output logic              cpu_resp_valid,
    output cache_data_t       cpu_resp_data,
    output cache_req_t        data_req,
    output cache_data_t       data_write,
    input  cache_data_t       data_read,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output cache_data_t       mem_wdata,
    input  logic              mem_rdata_valid,
    input  cache_data_t       mem_rdata
);

    cache_ctrl_state_t state_q, state_d;

    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    cache_data_t       req_wdata_q;
    logic [TAG_W-1:0]  victim_tag_q;
    cache_data_t       victim_data_q;
    cache_data_t       fill_data_q;
    cache_data_t       resp_data_q;

    logic               tag_rd_en;
    logic               tag_wr_en;
    tag_entry_t         tag_wr_entry;
    tag_entry_t         tag_rd_entry;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic               accept;
    logic               hit;

    assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];
    assign req_idx = req_addr_q[INDEX_W-1:0];
    assign accept  = (state_q == IDLE) && !rst && cpu_req_valid;
    assign hit     = tag_rd_entry.valid && (tag_rd_entry.tag == req_tag);

    assign cpu_resp_data = resp_data_q;

    cache_tag_array u_tag_array (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (tag_rd_en),
        .rd_index (cpu_addr[INDEX_W-1:0]),
        .rd_entry (tag_rd_entry),
        .wr_en    (tag_wr_en),
        .wr_index (req_idx),
        .wr_entry (tag_wr_entry)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus data-memory, tag-array and memory-channel controls.
    always_comb begin
        state_d        = state_q;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        data_req       = '0;
        data_write     = '0;
        mem_req_valid  = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        tag_rd_en      = 1'b0;
        tag_wr_en      = 1'b0;
        tag_wr_entry   = '0;
        case (state_q)
            IDLE: begin
                cpu_req_ready = !rst;
                if (accept) begin
                    data_req.index = cpu_addr[INDEX_W-1:0];
                    tag_rd_en      = 1'b1;
                    state_d        = LOOKUP;
                end
            end
            LOOKUP: begin
                data_req.index = req_idx;
                if (hit) begin
                    if (req_we_q) begin
                        data_req.we  = 1'b1;
                        data_write   = req_wdata_q;
                        tag_wr_en    = 1'b1;
                        tag_wr_entry = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
                    end
                    state_d = RESP;
                end else if (tag_rd_entry.valid && tag_rd_entry.dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = REFILL_REQ;
                end
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = {victim_tag_q, req_idx};
                mem_wdata     = victim_data_q;
                if (mem_req_ready) begin
                    state_d = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = req_addr_q;
                if (mem_req_ready) begin
                    state_d = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (mem_rdata_valid) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                data_req.index = req_idx;
                data_req.we    = 1'b1;
                data_write     = req_we_q ? req_wdata_q : fill_data_q;
                tag_wr_en      = 1'b1;
                tag_wr_entry   = '{valid: 1'b1, dirty: req_we_q, tag: req_tag};
                state_d        = RESP;
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request, victim, refill and response holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_we_q      <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            fill_data_q   <= '0;
            resp_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_we_q    <= cpu_we;
                        req_addr_q  <= cpu_addr;
                        req_wdata_q <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    victim_tag_q  <= tag_rd_entry.tag;
                    victim_data_q <= data_read;
                    if (hit) begin
                        resp_data_q <= req_we_q ? req_wdata_q : data_read;
                    end
                end
                REFILL_WAIT: begin
                    if (mem_rdata_valid) begin
                        fill_data_q <= mem_rdata;
                    end
                end
                FILL: begin
                    resp_data_q <= req_we_q ? req_wdata_q : fill_data_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
